// File: rtl/crot_gate_pipelined_if.sv
// Amplitude bus of the controlled phase-rotation stage.
// The master drives one input sample per cycle; the slave (the rotation
// stage) returns the delayed alpha, the rotated beta and its status flags.
interface crot_gate_pipelined_if #(
    parameter int DATA_W = 8
);

    logic                     in_valid;
    logic                     control;
    logic [2:0]               k;
    logic signed [DATA_W-1:0] alpha_r;
    logic signed [DATA_W-1:0] alpha_i;
    logic signed [DATA_W-1:0] beta_r;
    logic signed [DATA_W-1:0] beta_i;
    logic                     sat_clr;

    logic                     out_valid;
    logic signed [DATA_W-1:0] new_alpha_r;
    logic signed [DATA_W-1:0] new_alpha_i;
    logic signed [DATA_W-1:0] new_beta_r;
    logic signed [DATA_W-1:0] new_beta_i;
    logic                     sat_sticky;

    modport master (
        output in_valid, control, k, alpha_r, alpha_i, beta_r, beta_i, sat_clr,
        input  out_valid, new_alpha_r, new_alpha_i, new_beta_r, new_beta_i, sat_sticky
    );

    modport slave (
        input  in_valid, control, k, alpha_r, alpha_i, beta_r, beta_i, sat_clr,
        output out_valid, new_alpha_r, new_alpha_i, new_beta_r, new_beta_i, sat_sticky
    );

endinterface

// File: rtl/crot_gate_pipelined.sv
// Controlled phase rotation R_k for the reduced QFT datapath.
// With control=1, beta is multiplied by e^(j*pi/2^(k-1)); alpha always
// passes through unchanged. The latency is a fixed 4 cycles, which matches
// the upstream Hadamard stage. The pipeline never stalls: the data registers
// load every cycle, and a valid bit travels alongside the data.
//   stage 1: register the inputs and pick the twiddle (S3.4, 16 = 1.0)
//   stage 2: four signed products
//   stage 3: combine, arithmetic shift by FRAC_W, saturate
//   stage 4: output registers
module crot_gate_pipelined #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crot_gate_pipelined_if.slave  bus
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int DEPTH  = 4;

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_W - 1)));

    // Clamp a widened value into DATA_W bits; the MSB of the result is the
    // saturation flag.
    function automatic logic [DATA_W:0] saturate(input logic signed [SUM_W-1:0] v);
        logic [DATA_W:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            r = {1'b0, v[DATA_W-1:0]};
        end
        return r;
    endfunction

    // valid sideband, one bit per stage
    logic [DEPTH-1:0] valid_reg;

    // alpha delay line: 4 plain registers, never modified
    logic signed [DATA_W-1:0] alpha_r_reg [DEPTH];
    logic signed [DATA_W-1:0] alpha_i_reg [DEPTH];

    // stage 1
    logic signed [DATA_W-1:0] beta_r_s1_reg;
    logic signed [DATA_W-1:0] beta_i_s1_reg;
    logic signed [DATA_W-1:0] cos_s1_reg;
    logic signed [DATA_W-1:0] sin_s1_reg;
    logic signed [DATA_W-1:0] cos_next;
    logic signed [DATA_W-1:0] sin_next;

    // stage 2
    logic signed [PROD_W-1:0] pr_c_reg;
    logic signed [PROD_W-1:0] pi_s_reg;
    logic signed [PROD_W-1:0] pr_s_reg;
    logic signed [PROD_W-1:0] pi_c_reg;

    // stage 3
    logic signed [SUM_W-1:0]  re_sum;
    logic signed [SUM_W-1:0]  im_sum;
    logic [DATA_W:0]          re_sat_next;
    logic [DATA_W:0]          im_sat_next;
    logic signed [DATA_W-1:0] re_s3_reg;
    logic signed [DATA_W-1:0] im_s3_reg;
    logic                     re_sat_s3_reg;
    logic                     im_sat_s3_reg;

    // stage 4
    logic signed [DATA_W-1:0] re_s4_reg;
    logic signed [DATA_W-1:0] im_s4_reg;
    logic                     re_sat_s4_reg;
    logic                     im_sat_s4_reg;

    logic                     sat_sticky_reg;

    // Twiddle table for e^(j*pi/2^(k-1)). control=0 and k=0 both select identity.
    always_comb begin
        cos_next = DATA_W'(16);
        sin_next = DATA_W'(0);
        if (bus.control) begin
            case (bus.k)
                3'd1: begin cos_next = DATA_W'(-16); sin_next = DATA_W'(0);  end
                3'd2: begin cos_next = DATA_W'(0);   sin_next = DATA_W'(16); end
                3'd3: begin cos_next = DATA_W'(11);  sin_next = DATA_W'(11); end
                3'd4: begin cos_next = DATA_W'(15);  sin_next = DATA_W'(6);  end
                3'd5: begin cos_next = DATA_W'(16);  sin_next = DATA_W'(3);  end
                3'd6: begin cos_next = DATA_W'(16);  sin_next = DATA_W'(2);  end
                3'd7: begin cos_next = DATA_W'(16);  sin_next = DATA_W'(1);  end
                default: begin cos_next = DATA_W'(16); sin_next = DATA_W'(0); end
            endcase
        end
    end

    // Shift the valid bit through the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[DEPTH-2:0], bus.in_valid};
        end
    end

    // Carry alpha through the 4-stage delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                alpha_r_reg[i] <= '0;
                alpha_i_reg[i] <= '0;
            end
        end else begin
            alpha_r_reg[0] <= bus.alpha_r;
            alpha_i_reg[0] <= bus.alpha_i;
            for (int i = 1; i < DEPTH; i++) begin
                alpha_r_reg[i] <= alpha_r_reg[i-1];
                alpha_i_reg[i] <= alpha_i_reg[i-1];
            end
        end
    end

    // Stage 1: capture beta and the selected twiddle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beta_r_s1_reg <= '0;
            beta_i_s1_reg <= '0;
            cos_s1_reg    <= '0;
            sin_s1_reg    <= '0;
        end else begin
            beta_r_s1_reg <= bus.beta_r;
            beta_i_s1_reg <= bus.beta_i;
            cos_s1_reg    <= cos_next;
            sin_s1_reg    <= sin_next;
        end
    end

    // Stage 2: form the four cross products at full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_c_reg <= '0;
            pi_s_reg <= '0;
            pr_s_reg <= '0;
            pi_c_reg <= '0;
        end else begin
            pr_c_reg <= PROD_W'(beta_r_s1_reg) * PROD_W'(cos_s1_reg);
            pi_s_reg <= PROD_W'(beta_i_s1_reg) * PROD_W'(sin_s1_reg);
            pr_s_reg <= PROD_W'(beta_r_s1_reg) * PROD_W'(sin_s1_reg);
            pi_c_reg <= PROD_W'(beta_i_s1_reg) * PROD_W'(cos_s1_reg);
        end
    end

    // Combine the products one bit wider, drop the fraction (floor), then clamp.
    always_comb begin
        re_sum      = (SUM_W'(pr_c_reg) - SUM_W'(pi_s_reg)) >>> FRAC_W;
        im_sum      = (SUM_W'(pr_s_reg) + SUM_W'(pi_c_reg)) >>> FRAC_W;
        re_sat_next = saturate(re_sum);
        im_sat_next = saturate(im_sum);
    end

    // Stage 3: register the saturated components and their flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_s3_reg     <= '0;
            im_s3_reg     <= '0;
            re_sat_s3_reg <= 1'b0;
            im_sat_s3_reg <= 1'b0;
        end else begin
            re_s3_reg     <= re_sat_next[DATA_W-1:0];
            im_s3_reg     <= im_sat_next[DATA_W-1:0];
            re_sat_s3_reg <= re_sat_next[DATA_W];
            im_sat_s3_reg <= im_sat_next[DATA_W];
        end
    end

    // Stage 4: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_s4_reg     <= '0;
            im_s4_reg     <= '0;
            re_sat_s4_reg <= 1'b0;
            im_sat_s4_reg <= 1'b0;
        end else begin
            re_s4_reg     <= re_s3_reg;
            im_s4_reg     <= im_s3_reg;
            re_sat_s4_reg <= re_sat_s3_reg;
            im_sat_s4_reg <= im_sat_s3_reg;
        end
    end

    // Sticky flag: set by a valid saturated output, cleared by sat_clr; set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky_reg <= 1'b0;
        end else if (valid_reg[DEPTH-1] && (re_sat_s4_reg || im_sat_s4_reg)) begin
            sat_sticky_reg <= 1'b1;
        end else if (bus.sat_clr) begin
            sat_sticky_reg <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_reg[DEPTH-1];
    assign bus.new_alpha_r = alpha_r_reg[DEPTH-1];
    assign bus.new_alpha_i = alpha_i_reg[DEPTH-1];
    assign bus.new_beta_r  = re_s4_reg;
    assign bus.new_beta_i  = im_s4_reg;
    assign bus.sat_sticky  = sat_sticky_reg;

endmodule

// File: tb/tb_crot_gate_pipelined.sv
// Self-checking bench for crot_gate_pipelined: directed test-plan vectors,
// then randomized traffic against a behavioural model of the rotation.
module tb_crot_gate_pipelined;

    typedef struct {
        bit v;
        int ar;
        int ai;
        int br;
        int bi;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   sticky_m = 1'b0;
    exp_t hist [64];
    exp_t zero_e;

    int cos_t [8] = '{16, -16, 0, 11, 15, 16, 16, 16};
    int sin_t [8] = '{0, 0, 16, 11, 6, 3, 2, 1};

    crot_gate_pipelined_if #(.DATA_W(8)) bus ();

    crot_gate_pipelined #(
        .DATA_W(8),
        .FRAC_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor division by 16 written with ordinary integer arithmetic.
    function automatic int floor16(input int x);
        if (x >= 0) return x / 16;
        return -((-x + 15) / 16);
    endfunction

    function automatic int clamp(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    // Behavioural model: rotate beta by the tabulated twiddle with floor scaling.
    function automatic exp_t model(input bit v, input bit ctl, input int kk,
                                   input int ar, input int ai, input int br, input int bi);
        exp_t e;
        int c, s, re, im;
        c = 16;
        s = 0;
        if (ctl) begin
            c = cos_t[kk];
            s = sin_t[kk];
        end
        re = floor16(br * c - bi * s);
        im = floor16(br * s + bi * c);
        e.v   = v;
        e.ar  = ar;
        e.ai  = ai;
        e.br  = clamp(re);
        e.bi  = clamp(im);
        e.sat = (clamp(re) != re) || (clamp(im) != im);
        return e;
    endfunction

    // Advance to the next falling edge and compare outputs with the model.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        e = hist[(cyc - 4) & 63];
        check_val("out_valid", int'(bus.out_valid), int'(e.v));
        check_val("alpha_r", int'(bus.new_alpha_r), e.ar);
        check_val("alpha_i", int'(bus.new_alpha_i), e.ai);
        check_val("beta_r", int'(bus.new_beta_r), e.br);
        check_val("beta_i", int'(bus.new_beta_i), e.bi);
        check_val("sat_sticky", int'(bus.sat_sticky), int'(sticky_m));
    endtask

    // Drive one input sample and record what should emerge 4 cycles later.
    task automatic drive(input bit v, input bit ctl, input int kk, input int ar, input int ai,
                         input int br, input int bi, input bit clr);
        exp_t e_out;
        e_out = hist[(cyc - 4) & 63];
        bus.in_valid = v;
        bus.control  = ctl;
        bus.k        = 3'(kk);
        bus.alpha_r  = 8'(ar);
        bus.alpha_i  = 8'(ai);
        bus.beta_r   = 8'(br);
        bus.beta_i   = 8'(bi);
        bus.sat_clr  = clr;
        if (!rst_n) begin
            hist[cyc & 63] = zero_e;
            sticky_m = 1'b0;
        end else begin
            hist[cyc & 63] = model(v, ctl, kk, ar, ai, br, bi);
            if (e_out.v && e_out.sat) sticky_m = 1'b1;
            else if (clr) sticky_m = 1'b0;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_out(input string tag, input int v, input int ar, input int ai,
                           input int br, input int bi);
        check_val({tag, "_valid"}, int'(bus.out_valid), v);
        check_val({tag, "_ar"}, int'(bus.new_alpha_r), ar);
        check_val({tag, "_ai"}, int'(bus.new_alpha_i), ai);
        check_val({tag, "_br"}, int'(bus.new_beta_r), br);
        check_val({tag, "_bi"}, int'(bus.new_beta_i), bi);
    endtask

    // Assert reset in the drive slot: outputs must clear at once, in-flight data is lost.
    task automatic reset_cycle(input string tag);
        rst_n = 1'b0;
        #1;
        chk_out(tag, 0, 0, 0, 0, 0);
        check_val({tag, "_sticky"}, int'(bus.sat_sticky), 0);
        for (int i = 1; i <= 3; i++) hist[(cyc - i) & 63] = zero_e;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nv;
        int vals [4];
        zero_e = '{default: 0};
        for (int i = 0; i < 64; i++) hist[i] = zero_e;
        bus.in_valid = 1'b0;
        bus.control  = 1'b0;
        bus.k        = 3'd0;
        bus.alpha_r  = '0;
        bus.alpha_i  = '0;
        bus.beta_r   = '0;
        bus.beta_i   = '0;
        bus.sat_clr  = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        check_val("reset_sticky", int'(bus.sat_sticky), 0);
        repeat (3) begin tick(); idle(); end
        tick();
        rst_n = 1'b1;
        idle();
        repeat (4) begin tick(); idle(); end

        // Identity (control=0)
        tick(); drive(1, 0, 3, 20, -5, 32, 16, 0);
        repeat (3) begin tick(); idle(); end
        tick(); chk_out("ident", 1, 20, -5, 32, 16);
        check_val("ident_sticky", int'(bus.sat_sticky), 0);
        idle();

        // Back-to-back rotations with different k
        tick(); drive(1, 1, 2, 0, 0, 16, 0, 0);
        tick(); drive(1, 1, 3, 0, 0, 32, 16, 0);
        repeat (2) begin tick(); idle(); end
        tick(); chk_out("rot_k2", 1, 0, 0, 0, 16); idle();
        tick(); chk_out("rot_k3", 1, 0, 0, 11, 33); idle();

        // Negative truncation toward -inf
        tick(); drive(1, 1, 3, 0, 0, -1, 0, 0);
        repeat (3) begin tick(); idle(); end
        tick(); chk_out("neg_trunc", 1, 0, 0, -1, -1); idle();

        // Saturation and the sticky flag
        tick(); drive(1, 1, 1, 0, 0, -128, 0, 0);
        tick(); drive(1, 1, 3, 0, 0, 127, 127, 0);
        repeat (2) begin tick(); idle(); end
        tick(); chk_out("sat_k1", 1, 0, 0, 127, 0);
        check_val("sat_k1_sticky_pre", int'(bus.sat_sticky), 0); idle();
        tick(); chk_out("sat_k3", 1, 0, 0, 0, 127);
        check_val("sat_sticky_set", int'(bus.sat_sticky), 1); idle();
        tick(); check_val("sat_sticky_hold", int'(bus.sat_sticky), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(); check_val("sat_sticky_clr", int'(bus.sat_sticky), 0); idle();

        // Saturating bubble must not set the flag
        tick(); drive(0, 1, 1, 0, 0, -128, 0, 0);
        repeat (5) begin tick(); idle(); end
        tick(); check_val("bubble_sticky", int'(bus.sat_sticky), 0); idle();

        // Reset mid-flight
        tick(); drive(1, 0, 0, 1, 2, 3, 4, 0);
        tick(); drive(1, 0, 0, 5, 6, 7, 8, 0);
        tick(); reset_cycle("rst_mid");
        tick(); rst_n = 1'b1; drive(1, 0, 0, 9, 10, 11, 12, 0);
        nv = 0;
        repeat (6) begin
            tick();
            if (bus.out_valid) begin
                nv++;
                check_val("rst_survivor_ar", int'(bus.new_alpha_r), 9);
            end
            idle();
        end
        check_val("rst_valid_count", nv, 1);

        // Chained after the Hadamard stage
        tick(); drive(1, 1, 3, 16, 0, 16, 0, 0);
        repeat (3) begin tick(); idle(); end
        tick(); chk_out("chain", 1, 16, 0, 11, 11); idle();

        // Randomized traffic
        repeat (400) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 3) == 0) vals[j] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                else vals[j] = int'($urandom_range(0, 255)) - 128;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  vals[0], vals[1], vals[2], vals[3], ($urandom_range(0, 15) == 0));
        end
        repeat (6) begin tick(); idle(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
